aes_key_sched_ctrl: RTL
=======================

// Module: aes_key_sched_ctrl
// PURPOSE
//  Sequencer for AES-128 key expansion. Accepts a 128-bit cipher key and emits
//  round keys 0..NR, one per valid/ready handshake, to the round datapath.
//  Drives the round index into the Rcon lookup.
//  Time-shares an external 32-bit SubWord unit (4 S-boxes).
// PARAMETERS
//  NR        10  last round-key index (AES-128)
//  SBOX_LAT  1   cycles from sub_in stable to sub_out valid (>=1)
// PORTS
//  clk         in   1    single clock; all state on rising edge
//  rst         in   1    asynchronous, active-high reset
//  key_in      in   128  cipher key; w0 = key_in[127:96]
//  key_valid   in   1    key_in valid
//  key_ready   out  1    high only in IDLE
//  rcon_round  out  4    round index to Rcon lookup
//  rcon_word   in   32   Rcon result (combinational, byte in [31:24])
//  sub_in      out  32   RotWord(w3) presented to SubWord unit
//  sub_out     in   32   SubWord(sub_in), valid SBOX_LAT cycles after sub_in
//  rk_data     out  128  current round key {w0,w1,w2,w3}
//  rk_index    out  4    index of rk_data, 0..NR
//  rk_valid    out  1    rk_data/rk_index valid
//  rk_ready    in   1    consumer accepts on rk_valid & rk_ready
//  busy        out  1    high in every state except IDLE
//  done        out  1    1-cycle pulse after rk_index==NR is accepted
// BEHAVIOUR
//  Reset:
//   - state=IDLE; all outputs 0 except key_ready=1.
//   - Async assert aborts any schedule mid-key; no done pulse.
//  FSM IDLE -> EMIT -> SUB -> CALC -> EMIT ... -> FIN -> IDLE
//  - IDLE: on key_valid & key_ready, capture key_in into w[0..3]; rk_index=0; ->EMIT.
//  - EMIT:
//     - rk_valid=1; rk_data/rk_index held stable while rk_ready=0.
//     - On handshake: if rk_index==NR -> FIN, else -> SUB with rcon_round=rk_index+1.
//  - SUB:
//     - sub_in = {w3[23:0],w3[31:24]}, held stable for SBOX_LAT cycles
//       (cycle counter).
//     - In the last cycle, register temp = sub_out ^ rcon_word; ->CALC.
//  - CALC (1 cycle):
//     - w0'=w0^temp; w1'=w1^w0'; w2'=w2^w1'; w3'=w3^w2'.
//     - rk_index++; ->EMIT.
//  - FIN: done=1 for one cycle; rcon_round=0; ->IDLE.
//  Outputs:
//   - rcon_round = 0 outside SUB/CALC.
//   - sub_in = 0 outside SUB.
//   - rk_valid only in EMIT.
//  Latency (rk_ready held 1):
//   - rk0 valid 1 cycle after key accept.
//   - rk(n+1) valid SBOX_LAT+2 cycles after rk(n) valid.
//   - With SBOX_LAT=1, rk10 is valid 31 cycles after accept.
//  Boundaries:
//   - key_valid outside IDLE ignored; key_in changes after capture have no effect.
//   - rk_ready high before rk_valid does not pre-accept.
//   - done and key_ready=1 never overlap: FIN precedes IDLE.
//   - Arithmetic is pure XOR; no carries.
//   - rk_index, rcon_round never exceed NR.
// STRUCTURE
//  Shared package:
//   - state enum (IDLE, EMIT, SUB, CALC, FIN)
//   - AES_NR=10, AES_KEY_W=128, AES_WORD_W=32
//   - rot_word() function
//  One sub-module is natural: aes_key_word_step (temp/w0..w3 -> next w0..w3,
//  combinational); the existing Rcon lookup is instantiated outside this block.
//  SubWord unit stays external so the round datapath can share the S-boxes.
// TESTING
//  1. Key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1 -> rk1=a0fafe1788542cb123a339392a6c7605,
//     rk10=d014f9a8c9ee2589e13f0cc8b6630ca6, done 1 cycle after rk10 handshake.
//  2. Key 000102030405060708090a0b0c0d0e0f -> rk10=13111d7fe3944a17f307a78b4d2b30c5;
//     rcon_round sequence 1..10; rcon_round=0 in IDLE/EMIT.
//  3. rk_ready random 50% -> rk_data/rk_index stable while stalled;
//     11 handshakes, indices 0..10 in order, no gaps.
//  4. key_valid pulsed while busy with a different key -> ignored;
//     output matches first key; key_ready=0 until after done.
//  5. rst asserted while rk_index=5 in SUB -> next cycle state IDLE, rk_valid=0, key_ready=1;
//     no done pulse; a new key then schedules correctly.
//  6. SBOX_LAT=3 with a delayed SubWord model -> same keys as test 1;
//     rk(n)->rk(n+1) spacing is 5 cycles.

Source files
------------

// File: rtl/aes_key_sched_ctrl_pkg.sv
// Shared types and constants for the AES-128 key-schedule sequencer.
package aes_key_sched_ctrl_pkg;

   localparam int AES_NR     = 10;
   localparam int AES_KEY_W  = 128;
   localparam int AES_WORD_W = 32;

   typedef enum logic [2:0] {
      IDLE,
      EMIT,
      SUB,
      CALC,
      FIN
   } state_e;

   // One-byte left rotation of a schedule word.
   function automatic logic [AES_WORD_W-1:0] rot_word(input logic [AES_WORD_W-1:0] w);
      return {w[AES_WORD_W-9:0], w[AES_WORD_W-1:AES_WORD_W-8]};
   endfunction

endpackage

// File: rtl/aes_key_word_step.sv
// Combinational XOR chain producing the next four schedule words from temp.
module aes_key_word_step
   import aes_key_sched_ctrl_pkg::*;
(
   input  logic [127:0] w_i,
   input  logic [31:0]  temp_i,
   output logic [127:0] w_o
);

   logic [AES_WORD_W-1:0] w0_d, w1_d, w2_d, w3_d;

   always_comb begin
      w0_d = w_i[127:96] ^ temp_i;
      w1_d = w_i[95:64]  ^ w0_d;
      w2_d = w_i[63:32]  ^ w1_d;
      w3_d = w_i[31:0]   ^ w2_d;
      w_o  = {w0_d, w1_d, w2_d, w3_d};
   end

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key-expansion sequencer: emits round keys 0..NR over a valid/ready
// handshake, time-sharing an external SubWord unit and Rcon lookup.
module aes_key_sched_ctrl
   import aes_key_sched_ctrl_pkg::*;
#(
   parameter int NR       = AES_NR,
   parameter int SBOX_LAT = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [127:0] key_in,
   input  logic         key_valid,
   output logic         key_ready,
   output logic [3:0]   rcon_round,
   input  logic [31:0]  rcon_word,
   output logic [31:0]  sub_in,
   input  logic [31:0]  sub_out,
   output logic [127:0] rk_data,
   output logic [3:0]   rk_index,
   output logic         rk_valid,
   input  logic         rk_ready,
   output logic         busy,
   output logic         done
);

   localparam int               CNT_W    = (SBOX_LAT > 1) ? $clog2(SBOX_LAT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SBOX_LAT - 1);
   localparam logic [3:0]       IDX_LAST = 4'(NR);

   state_e             state_q;
   logic [127:0]       w_q;
   logic [127:0]       w_d;
   logic [31:0]        temp_q;
   logic [3:0]         idx_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               key_ready_q;
   logic               rk_valid_q;
   logic               busy_q;
   logic               done_q;
   logic [3:0]         rcon_q;
   logic [31:0]        sub_in_q;

   aes_key_word_step u_step (
      .w_i    (w_q),
      .temp_i (temp_q),
      .w_o    (w_d)
   );

   // Every output is a flop updated alongside the state transition.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         w_q         <= '0;
         temp_q      <= '0;
         idx_q       <= '0;
         cnt_q       <= '0;
         key_ready_q <= 1'b1;
         rk_valid_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         rcon_q      <= '0;
         sub_in_q    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (key_valid && key_ready_q) begin
                  w_q         <= key_in;
                  idx_q       <= '0;
                  key_ready_q <= 1'b0;
                  busy_q      <= 1'b1;
                  rk_valid_q  <= 1'b1;
                  state_q     <= EMIT;
               end
            end
            EMIT: begin
               if (rk_ready) begin
                  rk_valid_q <= 1'b0;
                  if (idx_q == IDX_LAST) begin
                     done_q  <= 1'b1;
                     state_q <= FIN;
                  end else begin
                     rcon_q   <= idx_q + 4'd1;
                     sub_in_q <= rot_word(w_q[31:0]);
                     cnt_q    <= '0;
                     state_q  <= SUB;
                  end
               end
            end
            SUB: begin
               // sub_in stays put until the SubWord result has been captured.
               if (cnt_q == CNT_LAST) begin
                  temp_q   <= sub_out ^ rcon_word;
                  sub_in_q <= '0;
                  state_q  <= CALC;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            CALC: begin
               w_q        <= w_d;
               idx_q      <= idx_q + 4'd1;
               rcon_q     <= '0;
               rk_valid_q <= 1'b1;
               state_q    <= EMIT;
            end
            FIN: begin
               done_q      <= 1'b0;
               busy_q      <= 1'b0;
               key_ready_q <= 1'b1;
               state_q     <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign key_ready  = key_ready_q;
   assign rcon_round = rcon_q;
   assign sub_in     = sub_in_q;
   assign rk_data    = w_q;
   assign rk_index   = idx_q;
   assign rk_valid   = rk_valid_q;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule
